// File: rtl/kernel_conv_pipe.sv
// kernel_conv_pipe: streaming KxK signed convolution (products, row sums, total, output register) with valid/ready on both sides.
// Optional macro KCONV_SATURATE_EN: clamp the total to ACC_W and flag out_ovf; otherwise the total wraps and out_ovf is 0.
module kernel_conv_pipe #(
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_wr,
  input  logic [$clog2(K*K)-1:0]     coef_idx,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K*K*DATA_W-1:0]      in_win,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_result,
  output logic                       out_ovf
);

  localparam int KK     = K * K;
  localparam int IDX_W  = $clog2(KK);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ROW_W  = PROD_W + $clog2(K);
  localparam int FULL_W = PROD_W + $clog2(KK);
  localparam logic [IDX_W:0] KK_LIM = (IDX_W + 1)'(KK);

  logic signed [COEF_W-1:0] coef_q [KK];
  logic signed [COEF_W-1:0] coef_d [KK];
  logic signed [DATA_W-1:0] pix    [KK];
  logic signed [PROD_W-1:0] prod_q [KK];
  logic signed [PROD_W-1:0] prod_d [KK];
  logic signed [ROW_W-1:0]  row_q  [K];
  logic signed [ROW_W-1:0]  row_d  [K];
  logic signed [FULL_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0]         res_q, res_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic out_valid_q, out_valid_d;
  logic adv;

`ifdef KCONV_SATURATE_EN
  localparam logic signed [FULL_W-1:0] SAT_MAX = {{(FULL_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN = ~SAT_MAX;
  logic ovf_q, ovf_d;
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
`endif

  always_comb begin
    for (int unsigned e = 0; e < KK; e++) begin
      pix[e] = in_win[e*DATA_W +: DATA_W];
    end
  end

  // Write lands at the edge, so a window accepted on the same edge still multiplies by coef_q.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr && ({1'b0, coef_idx} < KK_LIM)) begin
      coef_d[coef_idx] = coef_data;
    end
  end

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s3_valid_d  = s3_valid_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    row_d       = row_q;
    sum_d       = sum_q;
    res_d       = res_q;
`ifdef KCONV_SATURATE_EN
    ovf_d       = ovf_q;
`endif
    if (adv) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      s3_valid_d  = s2_valid_q;
      out_valid_d = s3_valid_q;
      if (in_valid) begin
        for (int unsigned e = 0; e < KK; e++) begin
          prod_d[e] = PROD_W'(pix[e]) * PROD_W'(coef_q[e]);
        end
      end
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < K; i++) begin
          row_d[i] = '0;
          for (int unsigned j = 0; j < K; j++) begin
            row_d[i] = row_d[i] + ROW_W'(prod_q[i*K + j]);
          end
        end
      end
      if (s2_valid_q) begin
        sum_d = '0;
        for (int unsigned i = 0; i < K; i++) begin
          sum_d = sum_d + FULL_W'(row_q[i]);
        end
      end
      if (s3_valid_q) begin
`ifdef KCONV_SATURATE_EN
        if (sum_q > SAT_MAX) begin
          res_d = SAT_MAX[ACC_W-1:0];
          ovf_d = 1'b1;
        end else if (sum_q < SAT_MIN) begin
          res_d = SAT_MIN[ACC_W-1:0];
          ovf_d = 1'b1;
        end else begin
          res_d = sum_q[ACC_W-1:0];
          ovf_d = 1'b0;
        end
`else
        res_d = sum_q[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q      <= '{default: '0};
      prod_q      <= '{default: '0};
      row_q       <= '{default: '0};
      sum_q       <= '0;
      res_q       <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef KCONV_SATURATE_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      coef_q      <= coef_d;
      prod_q      <= prod_d;
      row_q       <= row_d;
      sum_q       <= sum_d;
      res_q       <= res_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
`ifdef KCONV_SATURATE_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
`ifdef KCONV_SATURATE_EN
  assign out_ovf    = ovf_q;
`else
  assign out_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_conv_pipe.sv
// Scoreboard bench for kernel_conv_pipe: expected results come from a dot-product model over tracked coefficients.
module tb_kernel_conv_pipe;
  localparam int K      = 3;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 32;
  localparam int KK     = K * K;
  localparam int IDX_W  = $clog2(KK);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   coef_wr;
  logic [IDX_W-1:0]       coef_idx;
  logic [COEF_W-1:0]      coef_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [KK*DATA_W-1:0]   in_win;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_result;
  logic                   out_ovf;

  kernel_conv_pipe #(.K(K), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ACC_W-1:0] res; logic ovf; } exp_t;
  exp_t exp_q[$];
  int   mcoef[KK];
  int   push_pix[KK];
  int   win[KK];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  logic stalled_prev = 1'b0;
  logic [ACC_W-1:0] held_res;
  logic held_ovf;
  logic [DATA_W-1:0] push_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input int p[KK], input int c[KK]);
    exp_t   r;
    longint s;
`ifdef KCONV_SATURATE_EN
    longint mx;
    longint mn;
`endif
    s = 0;
    for (int e = 0; e < KK; e++) s += longint'(p[e]) * longint'(c[e]);
`ifdef KCONV_SATURATE_EN
    mx = (longint'(1) <<< (ACC_W - 1)) - 1;
    mn = -mx - 1;
    if (s > mx)      begin r.res = mx[ACC_W-1:0]; r.ovf = 1'b1; end
    else if (s < mn) begin r.res = mn[ACC_W-1:0]; r.ovf = 1'b1; end
    else             begin r.res = s[ACC_W-1:0];  r.ovf = 1'b0; end
`else
    r.res = s[ACC_W-1:0];
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  // Stimulus side: record what the next edge will accept or write.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      foreach (mcoef[e]) mcoef[e] = 0;
    end else begin
      if (in_valid && in_ready) begin
        for (int e = 0; e < KK; e++) begin
          push_t = in_win[e*DATA_W +: DATA_W];
          push_pix[e] = int'($signed(push_t));
        end
        exp_q.push_back(model(push_pix, mcoef));
      end
      if (coef_wr && int'(coef_idx) < KK) mcoef[coef_idx] = int'($signed(coef_data));
    end
  end

  // Monitor side: compare whatever the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (stalled_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_result", out_result, held_res);
        chk("stall_ovf", out_ovf, held_ovf);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_ovf", out_ovf, e.ovf);
        end
      end
      stalled_prev = out_valid && !out_ready;
      held_res     = out_result;
      held_ovf     = out_ovf;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic set_coef(input int idx, input int val);
    coef_wr   = 1'b1;
    coef_idx  = IDX_W'(idx);
    coef_data = COEF_W'(val);
    @(posedge clk); #1;
    coef_wr   = 1'b0;
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < KK; i++) set_coef(i, val);
  endtask

  task automatic send(input int p[KK], input bit wr, input int idx, input int val);
    int n;
    bit acc;
    for (int e = 0; e < KK; e++) in_win[e*DATA_W +: DATA_W] = DATA_W'(p[e]);
    in_valid  = 1'b1;
    coef_wr   = wr;
    coef_idx  = IDX_W'(idx);
    coef_data = COEF_W'(val);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      coef_wr = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_next(input string nm, input logic [ACC_W-1:0] r, input logic o);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = out_valid;
      n++;
    end
    if (seen) begin
      chk(nm, out_result, r);
      chk({nm, "_ovf"}, out_ovf, o);
    end else begin
      chk({nm, "_timeout"}, 0, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    in_valid = 1'b0; in_win = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // T1: latency and basic result
    set_all(1);
    foreach (win[e]) win[e] = 1;
    send(win, 1'b0, 0, 0);
    @(negedge clk); chk("T1_lat_n0", out_valid, 0);
    @(posedge clk); @(negedge clk); chk("T1_lat_n1", out_valid, 0);
    @(posedge clk); @(negedge clk); chk("T1_lat_n2", out_valid, 0);
    @(posedge clk); @(negedge clk); chk("T1_lat_n3", out_valid, 1);
    chk("T1_result", out_result, 9);
    chk("T1_ovf", out_ovf, 0);
    @(posedge clk); #1;

    // T2: negative pixels
    foreach (win[e]) win[e] = -1;
    send(win, 1'b0, 0, 0);
    expect_next("T2", 32'hFFFFFFF7, 1'b0);

    // T3: full-scale positive
    set_all(32767);
    foreach (win[e]) win[e] = 32767;
    send(win, 1'b0, 0, 0);
`ifdef KCONV_SATURATE_EN
    expect_next("T3", 32'h7FFFFFFF, 1'b1);
`else
    expect_next("T3", 32'd1073152009, 1'b0);
`endif

    // T4: random windows, random coefficient writes, random backpressure
    for (int i = 0; i < KK; i++) set_coef(i, rnd16());
    rand_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      foreach (win[e]) win[e] = rnd16();
      send(win, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd16());
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    // T5: same-edge coefficient write uses the old value
    set_all(0);
    foreach (win[e]) win[e] = 2;
    send(win, 1'b1, 4, 5);
    send(win, 1'b0, 0, 0);
    expect_next("T5_A", 32'd0, 1'b0);
    expect_next("T5_B", 32'd10, 1'b0);

    // T6: reset with windows in flight
    set_all(1);
    foreach (win[e]) win[e] = 1;
    send(win, 1'b0, 0, 0);
    send(win, 1'b0, 0, 0);
    send(win, 1'b0, 0, 0);
    reset = 1'b1;
    #1;
    chk("T6_rst_valid", out_valid, 0);
    chk("T6_rst_result", out_result, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("T6_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(win, 1'b0, 0, 0);
    expect_next("T6_cleared", 32'd0, 1'b0);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
